// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit.
// Stage k shifts by 2^k when its current low shamt bit is set. The stage
// passes on the remaining shamt bits, the mode, the operand sign bit and a
// valid flag. The whole pipe advances in lockstep whenever the output
// register is empty or is being drained. This gives a ready/valid stream
// with one beat per cycle and a fixed latency of SW cycles.
module barrel_shift_pipe #(
    parameter int WIDTH = 8,               // power of two, 2..64
    parameter int SW    = $clog2(WIDTH)    // derived; do not override alone
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    // One pipeline slot. The shamt field is consumed LSB-first. Each stage
    // shifts it right by one, so every stage looks only at bit 0.
    typedef struct packed {
        logic             valid;
        logic             sign;   // MSB of the original operand, for ASR fill
        mode_e            mode;
        logic [SW-1:0]    shamt;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q [SW];
    stage_t stage_d [SW];
    stage_t head;
    logic   adv;

    // Applies one power-of-two shift step to a slot and retires its shamt bit.
    function automatic stage_t shift_stage(input stage_t s, input int unsigned amt);
        stage_t           r;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] sign_fill;
        r         = s;
        ones      = '1;
        sign_fill = ~(ones >> amt);
        if (s.shamt[0]) begin
            case (s.mode)
                MODE_LSL: r.data = s.data << amt;
                MODE_LSR: r.data = s.data >> amt;
                MODE_ASR: r.data = (s.data >> amt) | (s.sign ? sign_fill : '0);
                MODE_ROL: r.data = (s.data << amt) | (s.data >> (WIDTH - amt));
                default:  r.data = s.data;
            endcase
        end
        r.shamt = s.shamt >> 1;
        return r;
    endfunction

    // The pipe moves only when the final slot is empty or being retired.
    // Reset also frees it, because reset flushes every slot anyway.
    assign adv       = rst | out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = stage_q[SW-1].valid;
    assign out_data  = stage_q[SW-1].data;

    // Next-state of every stage: stage 0 from the ports, others from predecessor.
    always_comb begin
        // NOTE: every variable this block writes gets a value on every pass, so no latch can form.
        head       = '0;
        head.valid = in_valid;
        head.sign  = in_data[WIDTH-1];
        head.mode  = mode_e'(in_mode);
        head.shamt = in_shamt;
        head.data  = in_data;
        stage_d[0] = shift_stage(head, 1);
        for (int k = 1; k < SW; k++) begin
            stage_d[k] = shift_stage(stage_q[k-1], 32'(1) << k);
        end
    end

    // Stage registers: flush valid bits on reset, advance all stages together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits are reset. Payload behind a cleared valid is never observed.
            for (int k = 0; k < SW; k++) begin
                stage_q[k].valid <= 1'b0;
            end
        end else if (adv) begin
            // NOTE: non-blocking assignment, so every stage samples its predecessor's pre-edge value.
            for (int k = 0; k < SW; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and randomised check of barrel_shift_pipe at WIDTH=8 and WIDTH=32.
module tb_barrel_shift_pipe;

    logic clk;
    logic rst;

    logic       v8, rdy8, ov8, ordy8;
    logic [7:0] d8, od8;
    logic [2:0] sh8;
    logic [1:0] m8;

    logic        v32, rdy32, ov32, ordy32;
    logic [31:0] d32, od32;
    logic [4:0]  sh32;
    logic [1:0]  m32;

    int total = 0;
    int bad   = 0;

    logic [7:0]  q8  [$];
    logic [31:0] q32 [$];
    logic        hold8  = 1'b0;
    logic [7:0]  held8  = '0;
    logic        hold32 = 1'b0;
    logic [31:0] held32 = '0;

    // Hand-computed corner vectors: data, shamt, mode, expected result.
    logic [7:0] dir_d   [12] = '{8'h7F, 8'h80, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                 8'h80, 8'h01, 8'h80, 8'h81, 8'h5A, 8'hC3};
    logic [2:0] dir_sh  [12] = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd1, 3'd7, 3'd7, 3'd7, 3'd2, 3'd1};
    logic [1:0] dir_m   [12] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3,
                                 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd2};
    logic [7:0] dir_exp [12] = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                 8'h01, 8'h80, 8'h01, 8'hC0, 8'h16, 8'hE1};

    barrel_shift_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .in_data   (d8),
        .in_shamt  (sh8),
        .in_mode   (m8),
        .out_valid (ov8),
        .out_ready (ordy8),
        .out_data  (od8)
    );

    barrel_shift_pipe #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v32),
        .in_ready  (rdy32),
        .in_data   (d32),
        .in_shamt  (sh32),
        .in_mode   (m32),
        .out_valid (ov32),
        .out_ready (ordy32),
        .out_data  (od32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bit-level reference: shift a w-bit operand by sh positions.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh,
                                              input logic [1:0] m, input int w);
        logic [63:0] mask;
        logic [63:0] x;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
        x    = d & mask;
        case (m)
            2'd0: r = x << sh;
            2'd1: r = x >> sh;
            2'd2: begin
                r = x >> sh;
                if (x[w-1]) r = r | (mask & ~(mask >> sh));
            end
            default: r = (x << sh) | (x >> (w - sh));
        endcase
        return r & mask;
    endfunction

    // One cycle on the 8-bit DUT: drive, check output against scoreboard, advance.
    task automatic cyc8(input logic v, input logic [7:0] d, input logic [2:0] sh,
                        input logic [1:0] m, input logic [7:0] exp, input logic ordy,
                        output logic acc);
        v8 = v; d8 = d; sh8 = sh; m8 = m; ordy8 = ordy;
        #1;
        if (hold8) begin
            check("hold_valid8", 64'(ov8), 64'(1'b1));
            check("hold_data8", 64'(od8), 64'(held8));
        end
        if (ov8 && !ordy8) check("stall_ready8", 64'(rdy8), 64'(1'b0));
        if (!ov8) check("idle_ready8", 64'(rdy8), 64'(1'b1));
        if (ov8) begin
            if (q8.size() == 0) begin
                check("spurious_out8", 64'(ov8), 64'(1'b0));
            end else begin
                check("result8", 64'(od8), 64'(q8[0]));
                if (ordy8) void'(q8.pop_front());
            end
        end
        hold8 = ov8 && !ordy8;
        held8 = od8;
        acc   = v && rdy8;
        if (acc) q8.push_back(exp);
        tick();
    endtask

    task automatic cyc32(input logic v, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] m, input logic [31:0] exp, input logic ordy,
                         output logic acc);
        v32 = v; d32 = d; sh32 = sh; m32 = m; ordy32 = ordy;
        #1;
        if (hold32) begin
            check("hold_valid32", 64'(ov32), 64'(1'b1));
            check("hold_data32", 64'(od32), 64'(held32));
        end
        if (ov32 && !ordy32) check("stall_ready32", 64'(rdy32), 64'(1'b0));
        if (ov32) begin
            if (q32.size() == 0) begin
                check("spurious_out32", 64'(ov32), 64'(1'b0));
            end else begin
                check("result32", 64'(od32), 64'(q32[0]));
                if (ordy32) void'(q32.pop_front());
            end
        end
        hold32 = ov32 && !ordy32;
        held32 = od32;
        acc    = v && rdy32;
        if (acc) q32.push_back(exp);
        tick();
    endtask

    task automatic drain8(input int budget);
        int   n = 0;
        logic a;
        while (q8.size() != 0 && n < budget) begin
            cyc8(1'b0, 8'h0, 3'h0, 2'h0, 8'h0, 1'b1, a);
            n++;
        end
        check("drain8_empty", 64'(q8.size()), 64'(0));
        repeat (3) cyc8(1'b0, 8'h0, 3'h0, 2'h0, 8'h0, 1'b1, a);
    endtask

    task automatic drain32(input int budget);
        int   n = 0;
        logic a;
        while (q32.size() != 0 && n < budget) begin
            cyc32(1'b0, 32'h0, 5'h0, 2'h0, 32'h0, 1'b1, a);
            n++;
        end
        check("drain32_empty", 64'(q32.size()), 64'(0));
        repeat (3) cyc32(1'b0, 32'h0, 5'h0, 2'h0, 32'h0, 1'b1, a);
    endtask

    initial begin
        logic       a;
        int         idx;
        int         c;
        logic [7:0] sd;

        // Reset, with a beat offered and the output stalled: it must be dropped.
        rst = 1'b1;
        v8 = 1'b1; d8 = 8'hAA; sh8 = 3'd1; m8 = 2'd0; ordy8 = 1'b0;
        v32 = 1'b0; d32 = '0; sh32 = '0; m32 = '0; ordy32 = 1'b1;
        tick();
        tick();
        check("rst_out_valid8", 64'(ov8), 64'(1'b0));
        check("rst_out_valid32", 64'(ov32), 64'(1'b0));
        check("rst_in_ready8", 64'(rdy8), 64'(1'b1));
        rst = 1'b0;
        v8 = 1'b0; ordy8 = 1'b1;
        repeat (4) cyc8(1'b0, 8'h0, 3'h0, 2'h0, 8'h0, 1'b1, a);

        // B5 << 4 = 50, exactly three cycles after acceptance.
        v8 = 1'b1; d8 = 8'hB5; sh8 = 3'd4; m8 = 2'd0; ordy8 = 1'b1;
        #1;
        check("lsl_accept", 64'(rdy8), 64'(1'b1));
        tick();
        v8 = 1'b0;
        check("lsl_lat1", 64'(ov8), 64'(1'b0));
        tick();
        check("lsl_lat2", 64'(ov8), 64'(1'b0));
        tick();
        check("lsl_valid", 64'(ov8), 64'(1'b1));
        check("lsl_data", 64'(od8), 64'h50);
        tick();
        check("lsl_gone", 64'(ov8), 64'(1'b0));

        // B5 by 3 in LSR / ASR / ROL back to back: 16, F6, AD on consecutive cycles.
        v8 = 1'b1; d8 = 8'hB5; sh8 = 3'd3; m8 = 2'd1;
        tick();
        m8 = 2'd2;
        tick();
        m8 = 2'd3;
        tick();
        v8 = 1'b0;
        check("b2b_v0", 64'(ov8), 64'(1'b1));
        check("b2b_lsr", 64'(od8), 64'h16);
        tick();
        check("b2b_v1", 64'(ov8), 64'(1'b1));
        check("b2b_asr", 64'(od8), 64'hF6);
        tick();
        check("b2b_v2", 64'(ov8), 64'(1'b1));
        check("b2b_rol", 64'(od8), 64'hAD);
        tick();
        check("b2b_gone", 64'(ov8), 64'(1'b0));

        // Corner vectors streamed back to back.
        for (int i = 0; i < 12; i++) begin
            cyc8(1'b1, dir_d[i], dir_sh[i], dir_m[i], dir_exp[i], 1'b1, a);
            check("dir_accept", 64'(a), 64'(1'b1));
        end
        drain8(20);

        // Eight-beat stream with a five-cycle output stall in the middle.
        idx = 0;
        c   = 0;
        while (idx < 8 && c < 40) begin
            sd = 8'(8'h3B + idx * 29);
            cyc8(1'b1, sd, 3'(idx), 2'(idx), 8'(ref_shift(64'(sd), idx % 8, 2'(idx), 8)),
                 !(c >= 4 && c < 9), a);
            if (a) idx++;
            c++;
        end
        check("stream_sent", 64'(idx), 64'(8));
        drain8(20);

        // Reset with three beats in flight, and a beat offered during reset.
        cyc8(1'b1, 8'h11, 3'd1, 2'd0, 8'h22, 1'b1, a);
        cyc8(1'b1, 8'h11, 3'd2, 2'd0, 8'h44, 1'b1, a);
        cyc8(1'b1, 8'h11, 3'd3, 2'd0, 8'h88, 1'b1, a);
        rst = 1'b1; v8 = 1'b1; d8 = 8'hFF; sh8 = 3'd0; ordy8 = 1'b0;
        #1;
        check("rst_ready_full", 64'(rdy8), 64'(1'b1));
        tick();
        rst = 1'b0; v8 = 1'b0; ordy8 = 1'b1;
        q8.delete();
        hold8 = 1'b0;
        check("rst_flush", 64'(ov8), 64'(1'b0));

        // First beat after reset: 3C, shamt 0, three cycles later.
        v8 = 1'b1; d8 = 8'h3C; sh8 = 3'd0; m8 = 2'd2;
        tick();
        v8 = 1'b0;
        check("post_rst_lat1", 64'(ov8), 64'(1'b0));
        tick();
        check("post_rst_lat2", 64'(ov8), 64'(1'b0));
        tick();
        check("post_rst_valid", 64'(ov8), 64'(1'b1));
        check("post_rst_data", 64'(od8), 64'h3C);
        tick();
        check("post_rst_gone", 64'(ov8), 64'(1'b0));
        repeat (5) cyc8(1'b0, 8'h0, 3'h0, 2'h0, 8'h0, 1'b1, a);

        // Random traffic and back-pressure, 8-bit.
        for (int i = 0; i < 150; i++) begin
            logic       rv;
            logic [7:0] rd;
            logic [2:0] rs;
            logic [1:0] rm;
            rv = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom);
            rs = 3'($urandom);
            rm = 2'($urandom);
            cyc8(rv, rd, rs, rm, 8'(ref_shift(64'(rd), int'(rs), rm, 8)),
                 $urandom_range(0, 3) != 0, a);
        end
        drain8(40);

        // Random traffic and back-pressure, 32-bit.
        for (int i = 0; i < 150; i++) begin
            logic        rv;
            logic [31:0] rd;
            logic [4:0]  rs;
            logic [1:0]  rm;
            rv = ($urandom_range(0, 3) != 0);
            rd = $urandom;
            rs = 5'($urandom);
            rm = 2'($urandom);
            cyc32(rv, rd, rs, rm, 32'(ref_shift(64'(rd), int'(rs), rm, 32)),
                  $urandom_range(0, 3) != 0, a);
        end
        drain32(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
